// File: rtl/seq_multiplier_ctrl_dp.sv
// Sequential shift-add multiplier, unsigned or two's complement per request.
// Works on magnitudes and applies the sign once at the end; optional early exit.
module seq_multiplier_ctrl_dp #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               abort,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    iter;
    logic             neg;
  } dp_t;

  state_t           state_q, state_d;
  dp_t              dp_q, dp_d;
  logic             accept, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;

  // abort wins over a coincident start
  assign accept = start & (state_q == IDLE) & ~abort;

  // |most-negative| is 2^(WIDTH-1), which still fits WIDTH bits unsigned
  assign mag_a = (signed_mode & multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign mag_b = (signed_mode & multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;

  assign last_iter = (dp_q.iter == LAST) | (EARLY_TERM & ~(|dp_q.mplier[WIDTH-1:1]));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (abort) state_d = IDLE; else if (last_iter) state_d = FIX;
      FIX:     state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dp_d = dp_q;
    if (accept) begin
      dp_d.mcand  = PW'(mag_a);
      dp_d.mplier = mag_b;
      dp_d.acc    = '0;
      dp_d.iter   = '0;
      dp_d.neg    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else if (state_q == CALC) begin
      if (dp_q.mplier[0]) dp_d.acc = dp_q.acc + dp_q.mcand;
      dp_d.mcand  = dp_q.mcand << 1;
      dp_d.mplier = dp_q.mplier >> 1;
      dp_d.iter   = dp_q.iter + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            product <= '0;
    else if (state_q == FIX && !abort)   product <= dp_q.neg ? (~dp_q.acc + PW'(1)) : dp_q.acc;
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier_ctrl_dp.sv
// Bench for seq_multiplier_ctrl_dp: four instances (W4, W8, W8 no early-exit, W16)
// checked against integer arithmetic for product and iteration count.
module tb_seq_multiplier_ctrl_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, sm = 1'b0, abort_r = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [3:0]  rdy, bsy, dn;
  logic [31:0] prod [4];
  logic [31:0] last [4];
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W  = (g == 0) ? 4 : (g == 3) ? 16 : 8;
    localparam bit ET = (g != 2);
    logic [2*W-1:0] p;
    seq_multiplier_ctrl_dp #(.WIDTH(W), .EARLY_TERM(ET)) u_dut (
      .clk(clk), .rst(rst),
      .start(start && sel == 2'(g)), .signed_mode(sm), .abort(abort_r && sel == 2'(g)),
      .multiplicand(a_in[W-1:0]), .multiplier(b_in[W-1:0]),
      .in_ready(rdy[g]), .busy(bsy[g]), .done(dn[g]), .product(p));
    assign prod[g] = 32'(p);
  end

  function automatic int wd(int g);
    return (g == 0) ? 4 : (g == 3) ? 16 : 8;
  endfunction

  // operand value as a mathematical integer
  function automatic longint val(int w, logic [15:0] x, bit s);
    longint v;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [31:0] ref_prod(int w, logic [15:0] a, logic [15:0] b, bit s);
    longint r;
    r = val(w, a, s) * val(w, b, s);
    return 32'(r & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int ref_k(int g, logic [15:0] b, bit s);
    longint mb;
    int k;
    mb = val(wd(g), b, s);
    if (mb < 0) mb = -mb;
    if (g == 2) return wd(g);
    k = 1;
    for (int i = 0; i < 16; i++) if ((mb >> i) & 1) k = i + 1;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept_op(input int g, input logic [15:0] a, input logic [15:0] b, input bit s);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[g] && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_start", rdy[g], 1);
    sel = 2'(g); a_in = a; b_in = b; sm = s; start = 1'b1;
    @(posedge clk); #1;
    // start stays high with new operands for one busy cycle; must be ignored
    a_in = 16'($urandom); b_in = 16'($urandom); sm = ~s;
    chk("busy_after_accept", bsy[g], 1);
  endtask

  task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b, input bit s);
    int n;
    logic [31:0] exp;
    exp = ref_prod(wd(g), a, b, s);
    accept_op(g, a, b, s);
    for (n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (dn[g]) break;
    end
    chk("latency", n, ref_k(g, b, s) + 1);
    chk("product", prod[g], exp);
    last[g] = exp;
    @(posedge clk); #1;
    chk("done_single", dn[g], 0);
    chk("ready_after_done", rdy[g], 1);
  endtask

  task automatic abort_op(input int g, input logic [15:0] a, input logic [15:0] b, input int at);
    bit seen;
    accept_op(g, a, b, 1'b0);
    start = 1'b0;
    for (int i = 1; i < at; i++) begin @(posedge clk); #1; end
    abort_r = 1'b1;
    @(posedge clk); #1;
    abort_r = 1'b0;
    chk("abort_busy", bsy[g], 0);
    chk("abort_ready", rdy[g], 1);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= dn[g]; end
    chk("abort_no_done", seen, 0);
    chk("abort_prod_kept", prod[g], last[g]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, b;
    int w, r;
    for (int g = 0; g < 4; g++) last[g] = '0;
    #12;
    for (int g = 0; g < 4; g++) begin
      chk("rst_product", prod[g], 0);
      chk("rst_done", dn[g], 0);
      chk("rst_busy", bsy[g], 0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 4; g++) chk("ready_after_rst", rdy[g], 1);

    run_op(0, 16'h3, 16'h5, 1'b0);   // k=3, 0x0F
    run_op(0, 16'h8, 16'h7, 1'b1);   // -56 = 0xC8
    run_op(0, 16'h8, 16'h8, 1'b1);   // 0x40
    run_op(1, 16'hFF, 16'hFF, 1'b0); // 0xFE01
    run_op(2, 16'hFF, 16'hFF, 1'b0);
    run_op(1, 16'hA5, 16'h0, 1'b0);  // k=1
    run_op(2, 16'hA5, 16'h0, 1'b0);  // k=8
    run_op(3, 16'h8000, 16'h8000, 1'b1);

    abort_op(1, 16'h33, 16'hFF, 2);
    run_op(1, 16'd12, 16'd10, 1'b0); // 120

    // async reset between edges mid-CALC
    accept_op(1, 16'h77, 16'hFF, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_product", prod[1], 0);
    chk("mid_rst_busy", bsy[1], 0);
    chk("mid_rst_done", dn[1], 0);
    for (int g = 0; g < 4; g++) last[g] = '0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", rdy[1], 1);

    for (int g = 0; g < 4; g++) begin
      w = wd(g);
      for (int s = 0; s < 2; s++) begin
        repeat (150) begin
          r = $urandom_range(0, 7);
          a = 16'($urandom);
          b = (r == 0) ? 16'h0 : (r == 1) ? 16'(1 << (w - 1)) : (r == 2) ? 16'hFFFF : 16'($urandom);
          if ($urandom_range(0, 7) == 0) a = 16'(1 << (w - 1));
          run_op(g, a, b, s[0]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
